// File: rtl/svm_window_classifier_pkg.sv
// Shared types and helpers for the sliding-window linear-SVM scorer.
package svm_pkg;

    localparam int unsigned N_BIN    = 9;
    localparam int unsigned SAT_W    = 64;
    localparam int unsigned TAG_ID_W = 16;

    // Per-beat sideband carried alongside the datapath; the window id is
    // held at TAG_ID_W and narrowed to the port width at the output.
    typedef struct packed {
        logic                first;
        logic                is_final;
        logic [TAG_ID_W-1:0] win;
    } beat_tag_t;

    function automatic int unsigned acc_w(input int unsigned fw,
                                          input int unsigned nf,
                                          input int unsigned blk);
        return fw + $clog2(nf * blk) + 1;
    endfunction

    // Clamp a wide signed value to the signed range of an fw-bit word.
    function automatic logic signed [SAT_W-1:0] sat_fw(input logic signed [SAT_W-1:0] x,
                                                       input int unsigned fw);
        logic signed [SAT_W-1:0] hi;
        logic signed [SAT_W-1:0] lo;
        hi = (SAT_W'(1) <<< (fw - 1)) - SAT_W'(1);
        lo = ~hi;
        if (x > hi) return hi;
        if (x < lo) return lo;
        return x;
    endfunction

endpackage

// File: rtl/svm_window_classifier_if.sv
// Block-beat input stream and per-window result stream of the SVM scorer.
interface svm_window_classifier_if #(
    parameter int unsigned FW   = 32,
    parameter int unsigned NF   = 36,
    parameter int unsigned SW_W = 11
);
    logic [NF*FW-1:0] fea;
    logic [NF*FW-1:0] wgt;
    logic [FW-1:0]    bias;
    logic             i_sof;
    logic             i_valid;
    logic             i_ready;
    logic             o_valid;
    logic             o_ready;
    logic [FW-1:0]    result;
    logic             is_person;
    logic [SW_W-1:0]  sw_id;

    modport master (
        output fea, wgt, bias, i_sof, i_valid, o_ready,
        input  i_ready, o_valid, result, is_person, sw_id
    );

    modport slave (
        input  fea, wgt, bias, i_sof, i_valid, o_ready,
        output i_ready, o_valid, result, is_person, sw_id
    );
endinterface

// File: rtl/svm_window_classifier_dot.sv
// Dot product of one block beat: registered products (S1) then registered sum (S2).
module svm_dot #(
    parameter int unsigned NF    = 36,
    parameter int unsigned FW    = 32,
    parameter int unsigned FRAC  = 28,
    parameter int unsigned ACC_W = 45
) (
    input  logic                    clk,
    input  logic [NF*FW-1:0]        fea,
    input  logic [NF*FW-1:0]        wgt,
    output logic signed [ACC_W-1:0] sum
);
    localparam int unsigned PW = 2 * FW;

    logic signed [PW-1:0]    full_c [NF];
    logic signed [ACC_W-1:0] prod_c [NF];
    logic signed [ACC_W-1:0] prod_q [NF];
    logic signed [ACC_W-1:0] tree_c;

    // Full-width signed product, floor-shifted back to the feature scale.
    always_comb begin
        for (int k = 0; k < int'(NF); k++) begin
            full_c[k] = PW'(signed'(fea[k*FW +: FW])) * PW'(signed'(wgt[k*FW +: FW]));
            prod_c[k] = ACC_W'(full_c[k] >>> FRAC);
        end
    end

    always_comb begin
        tree_c = '0;
        for (int k = 0; k < int'(NF); k++) begin
            tree_c = tree_c + prod_q[k];
        end
    end

    // Datapath only; validity travels with the tag pipe in the parent.
    always_ff @(posedge clk) begin
        prod_q <= prod_c;
        sum    <= tree_c;
    end

endmodule

// File: rtl/svm_window_classifier.sv
// Streaming linear-SVM window scorer: block counters, tag pipe, accumulator, saturation, result handshake.
module svm_window_classifier
    import svm_pkg::beat_tag_t, svm_pkg::acc_w, svm_pkg::sat_fw, svm_pkg::SAT_W, svm_pkg::TAG_ID_W;
#(
    parameter int unsigned FEA_I       = 4,
    parameter int unsigned FEA_F       = 28,
    parameter int unsigned N_CELL      = 4,
    parameter int unsigned N_BIN       = svm_pkg::N_BIN,
    parameter int unsigned BLK_PER_WIN = 105,
    parameter int unsigned N_WIN       = 1200,
    parameter int unsigned SW_W        = 11
) (
    input logic                    clk,
    input logic                    rst,
    svm_window_classifier_if.slave bus
);
    localparam int unsigned FW    = FEA_I + FEA_F;
    localparam int unsigned NF    = N_CELL * N_BIN;
    localparam int unsigned ACC_W = acc_w(FW, NF, BLK_PER_WIN);
    localparam int unsigned BLK_W = $clog2(BLK_PER_WIN);

    logic [BLK_W-1:0]        blk_cnt;
    logic [SW_W-1:0]         win_cnt;
    logic [BLK_W-1:0]        eff_blk_c;
    logic [SW_W-1:0]         eff_win_c;
    logic                    final_c;
    logic                    ready_c;
    logic                    accept_c;
    beat_tag_t               tag_c;
    beat_tag_t               s1_tag;
    beat_tag_t               s2_tag;
    logic                    s1_valid;
    logic                    s2_valid;
    logic signed [ACC_W-1:0] dot_sum;
    logic signed [ACC_W-1:0] acc;
    logic signed [ACC_W-1:0] acc_next_c;
    logic signed [ACC_W-1:0] total_c;
    logic signed [FW-1:0]    sat_c;
    logic                    out_valid;
    logic [FW-1:0]           result_q;
    logic                    person_q;
    logic [SW_W-1:0]         sw_id_q;

    // A start-of-frame beat is treated as block 0 of window 0 regardless of the counters.
    always_comb begin
        eff_blk_c = bus.i_sof ? '0 : blk_cnt;
        eff_win_c = bus.i_sof ? '0 : win_cnt;
        final_c   = (eff_blk_c == BLK_W'(BLK_PER_WIN - 1));
        tag_c     = '{first: (eff_blk_c == '0), is_final: final_c, win: TAG_ID_W'(eff_win_c)};
    end

    // Only a final beat can collide with a held result; everything else flows.
    assign ready_c  = !((blk_cnt == BLK_W'(BLK_PER_WIN - 1)) && out_valid && !bus.o_ready);
    assign accept_c = bus.i_valid && ready_c;

    always_ff @(posedge clk) begin
        if (rst) begin
            blk_cnt <= '0;
            win_cnt <= '0;
        end else if (accept_c) begin
            if (final_c) begin
                blk_cnt <= '0;
                win_cnt <= (eff_win_c == SW_W'(N_WIN - 1)) ? '0 : eff_win_c + SW_W'(1);
            end else begin
                blk_cnt <= eff_blk_c + BLK_W'(1);
                win_cnt <= eff_win_c;
            end
        end
    end

    svm_dot #(
        .NF    (NF),
        .FW    (FW),
        .FRAC  (FEA_F),
        .ACC_W (ACC_W)
    ) u_dot (
        .clk (clk),
        .fea (bus.fea),
        .wgt (bus.wgt),
        .sum (dot_sum)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid <= 1'b0;
            s2_valid <= 1'b0;
            s1_tag   <= '0;
            s2_tag   <= '0;
        end else begin
            s1_valid <= accept_c;
            s2_valid <= s1_valid;
            s1_tag   <= tag_c;
            s2_tag   <= s1_tag;
        end
    end

    always_comb begin
        acc_next_c = (s2_tag.first ? '0 : acc) + dot_sum;
        total_c    = acc_next_c + ACC_W'(signed'(bus.bias));
        sat_c      = FW'(sat_fw(SAT_W'(total_c), FW));
    end

    // Final beat loads the result register; it takes priority over a same-cycle drain.
    always_ff @(posedge clk) begin
        if (rst) begin
            acc       <= '0;
            out_valid <= 1'b0;
            result_q  <= '0;
            person_q  <= 1'b0;
            sw_id_q   <= '0;
        end else begin
            if (s2_valid) begin
                acc <= acc_next_c;
            end
            if (s2_valid && s2_tag.is_final) begin
                out_valid <= 1'b1;
                result_q  <= sat_c;
                person_q  <= !sat_c[FW-1] && (sat_c != '0);
                sw_id_q   <= SW_W'(s2_tag.win);
            end else if (out_valid && bus.o_ready) begin
                out_valid <= 1'b0;
            end
        end
    end

    assign bus.i_ready   = ready_c;
    assign bus.o_valid   = out_valid;
    assign bus.result    = result_q;
    assign bus.is_person = person_q;
    assign bus.sw_id     = sw_id_q;

endmodule

// File: tb/tb_svm_window_classifier.sv
// Directed bench for svm_window_classifier with 4 blocks per window and 3 windows per frame.
module tb_svm_window_classifier;

    localparam int unsigned FW   = 32;
    localparam int unsigned NF   = 36;
    localparam int unsigned SW_W = 2;

    // Q4.28 constants; biases stay inside the representable range of the bias port.
    localparam logic [FW-1:0] ONE      = 32'h1000_0000;
    localparam logic [FW-1:0] TWO      = 32'h2000_0000;
    localparam logic [FW-1:0] W32      = 32'h0080_0000;
    localparam logic [FW-1:0] BIAS_M8  = 32'h8000_0000;
    localparam logic [FW-1:0] BIAS_M25 = 32'hD800_0000;
    localparam logic [FW-1:0] BIAS_M45 = 32'hB800_0000;
    localparam logic [FW-1:0] POS2     = 32'h2000_0000;
    localparam logic [FW-1:0] NEG35    = 32'hC800_0000;
    localparam logic [FW-1:0] MAXV     = 32'h7FFF_FFFF;
    localparam logic [FW-1:0] MINV     = 32'h8000_0000;

    typedef struct {
        logic [FW-1:0]   r;
        logic            p;
        logic [SW_W-1:0] id;
        int              c;
    } rec_t;

    logic clk = 1'b0;
    logic rst;
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;
    int   acc_cyc = 0;
    int   t_acc;
    int   c;
    rec_t q[$];

    svm_window_classifier_if #(.FW(FW), .NF(NF), .SW_W(SW_W)) bus ();

    svm_window_classifier #(
        .FEA_I       (4),
        .FEA_F       (28),
        .N_CELL      (4),
        .N_BIN       (9),
        .BLK_PER_WIN (4),
        .N_WIN       (3),
        .SW_W        (SW_W)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (bus.o_valid && bus.o_ready) q.push_back('{bus.result, bus.is_person, bus.sw_id, cyc});
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic [FW-1:0] f, input logic [FW-1:0] w, input logic sof);
        bus.fea     = {NF{f}};
        bus.wgt     = {NF{w}};
        bus.i_sof   = sof;
        bus.i_valid = 1'b1;
    endtask

    task automatic send(input logic [FW-1:0] f, input logic [FW-1:0] w, input logic sof);
        bit done = 1'b0;
        int budget = 0;
        drive(f, w, sof);
        while (!done) begin
            @(negedge clk);
            if (bus.i_ready) begin
                done    = 1'b1;
                acc_cyc = cyc;
            end else if (++budget > 50) begin
                check("send_ready", 64'(bus.i_ready), 64'(1));
                done = 1'b1;
            end
            @(posedge clk);
            #1;
        end
        bus.i_valid = 1'b0;
        bus.i_sof   = 1'b0;
    endtask

    task automatic send_n(input int n, input logic [FW-1:0] f, input logic [FW-1:0] w, input logic sof_first);
        for (int i = 0; i < n; i++) send(f, w, sof_first && (i == 0));
    endtask

    task automatic wait_results(input int n);
        int b = 0;
        while (q.size() < n && b < 100) begin
            @(negedge clk);
            b++;
        end
        repeat (5) @(negedge clk);
        check("result_count", 64'(q.size()), 64'(n));
        @(posedge clk);
        #1;
    endtask

    task automatic pop_check(input string tag, input logic [FW-1:0] r, input logic p,
                             input logic [SW_W-1:0] id, output int cc);
        rec_t e;
        cc = -1;
        check({tag, "_present"}, 64'(q.size() != 0), 64'(1));
        if (q.size() != 0) begin
            e  = q.pop_front();
            cc = e.c;
            check({tag, "_result"}, 64'(e.r), 64'(r));
            check({tag, "_person"}, 64'(e.p), 64'(p));
            check({tag, "_sw_id"}, 64'(e.id), 64'(id));
        end
    endtask

    initial begin
        rst         = 1'b1;
        bus.fea     = '0;
        bus.wgt     = '0;
        bus.bias    = '0;
        bus.i_sof   = 1'b0;
        bus.i_valid = 1'b0;
        bus.o_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check("rst_o_valid", 64'(bus.o_valid), 64'(0));
        check("rst_result", 64'(bus.result), 64'(0));
        check("rst_is_person", 64'(bus.is_person), 64'(0));
        check("rst_sw_id", 64'(bus.sw_id), 64'(0));
        check("rst_i_ready", 64'(bus.i_ready), 64'(1));
        @(posedge clk);
        #1;

        // Basic score: 4 x 1.125 - 8.0 = -3.5, three cycles after the final beat.
        bus.bias = BIAS_M8;
        send_n(4, ONE, W32, 1'b0);
        t_acc = acc_cyc;
        wait_results(1);
        pop_check("t1", NEG35, 1'b0, 2'd0, c);
        check("t1_latency", 64'(c), 64'(t_acc + 3));

        // Positive score over a whole frame and wrap of the window id.
        bus.bias = BIAS_M25;
        send_n(12, ONE, W32, 1'b1);
        send_n(4, ONE, W32, 1'b0);
        wait_results(4);
        pop_check("t2_w0", POS2, 1'b1, 2'd0, c);
        pop_check("t2_w1", POS2, 1'b1, 2'd1, c);
        pop_check("t2_w2", POS2, 1'b1, 2'd2, c);
        pop_check("t2_wrap", POS2, 1'b1, 2'd0, c);

        // Saturation in both directions, then an exact-zero score.
        bus.bias = '0;
        send_n(4, MAXV, MAXV, 1'b1);
        send_n(4, MINV, MAXV, 1'b0);
        wait_results(2);
        pop_check("t3_pos_sat", MAXV, 1'b1, 2'd0, c);
        pop_check("t3_neg_sat", MINV, 1'b0, 2'd1, c);
        bus.bias = BIAS_M45;
        send_n(4, ONE, W32, 1'b0);
        wait_results(1);
        pop_check("t3_zero", '0, 1'b0, 2'd2, c);

        // Backpressure: the 8th beat is a final beat and must wait for the held result.
        bus.bias    = BIAS_M25;
        bus.o_ready = 1'b0;
        send_n(7, ONE, W32, 1'b1);
        drive(ONE, W32, 1'b0);
        @(negedge clk);
        check("bp_i_ready", 64'(bus.i_ready), 64'(0));
        check("bp_o_valid", 64'(bus.o_valid), 64'(1));
        check("bp_result", 64'(bus.result), 64'(POS2));
        @(negedge clk);
        check("bp_hold_i_ready", 64'(bus.i_ready), 64'(0));
        check("bp_hold_result", 64'(bus.result), 64'(POS2));
        check("bp_hold_sw_id", 64'(bus.sw_id), 64'(0));
        @(posedge clk);
        #1;
        bus.o_ready = 1'b1;
        @(negedge clk);
        check("bp_release_i_ready", 64'(bus.i_ready), 64'(1));
        t_acc = cyc;
        @(posedge clk);
        #1;
        bus.i_valid = 1'b0;
        wait_results(2);
        pop_check("t4_first", POS2, 1'b1, 2'd0, c);
        pop_check("t4_second", POS2, 1'b1, 2'd1, c);
        check("t4_second_latency", 64'(c), 64'(t_acc + 3));

        // Resync: partial window 1 (heavier features) is dropped.
        send_n(4, ONE, W32, 1'b1);
        send_n(2, TWO, W32, 1'b0);
        send_n(4, ONE, W32, 1'b1);
        wait_results(2);
        pop_check("t5_before", POS2, 1'b1, 2'd0, c);
        pop_check("t5_resync", POS2, 1'b1, 2'd0, c);

        // Reset with a held result and a half-filled window in flight.
        bus.o_ready = 1'b0;
        send_n(4, ONE, W32, 1'b1);
        repeat (4) @(posedge clk);
        #1;
        send_n(2, TWO, W32, 1'b0);
        @(negedge clk);
        check("t6_pending", 64'(bus.o_valid), 64'(1));
        @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check("t6_o_valid", 64'(bus.o_valid), 64'(0));
        check("t6_result", 64'(bus.result), 64'(0));
        check("t6_is_person", 64'(bus.is_person), 64'(0));
        check("t6_sw_id", 64'(bus.sw_id), 64'(0));
        check("t6_i_ready", 64'(bus.i_ready), 64'(1));
        @(posedge clk);
        #1;
        bus.o_ready = 1'b1;
        send_n(4, ONE, W32, 1'b0);
        wait_results(1);
        pop_check("t6_after", POS2, 1'b1, 2'd0, c);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
